// File: rtl/aes_stream_if.sv
// aes_stream_if
//   Word-stream front end for the AES-128 encrypt path. Four 32-bit input
//   words are packed big-endian (word 0 -> [127:96]) into plain_text. The
//   block then waits CORE_LATENCY edges, captures cypher_text and streams it
//   back out as four 32-bit words over a valid/ready handshake.
//
//   Optional feature macro: AES_KEY_LOAD_EN
//     defined   : words accepted with in_key=1 load an internal key register
//                 that drives key_out; key_in is ignored.
//     undefined : key_out = key_in; in_key is ignored.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_data/in_valid  input word stream; in_ready high only in FILL
//   in_key            marks a key word (AES_KEY_LOAD_EN only)
//   plain_text        registered block to the encrypt path
//   key_in/key_out    external key in, key to key expansion out
//   cypher_text       result from the encrypt path
//   out_data/out_valid/out_ready  output word stream
//   busy              high in WAIT or DRAIN
//
// FSM
//   state   | meaning
//   S_FILL  | accepting input words
//   S_WAIT  | plain_text held, counting core latency
//   S_DRAIN | streaming captured result words out
module aes_stream_if #(
  parameter int CORE_LATENCY = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_key,
  output logic [127:0] plain_text,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  input  logic [127:0] cypher_text,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [7:0] LAT_LAST = 8'(CORE_LATENCY - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [1:0]   word_cnt;
  logic [1:0]   out_idx;
  logic [7:0]   lat_cnt;
  logic [127:0] out_buf;
  logic         is_key;
  logic         accept;

`ifdef AES_KEY_LOAD_EN
  logic [1:0]   key_cnt;
  logic [127:0] key_reg;
  logic [127:0] unused_key_in;

  assign unused_key_in = key_in;
  assign is_key        = in_key;
  assign key_out       = key_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt <= 2'd0;
      key_reg <= '0;
    end else if (accept && is_key) begin
      key_reg[{~key_cnt, 5'd0} +: 32] <= in_data;
      key_cnt <= key_cnt + 2'd1;
    end
  end
`else
  logic unused_in_key;

  assign unused_in_key = in_key;
  assign is_key        = 1'b0;
  assign key_out       = key_in;
`endif

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && !is_key && word_cnt == 2'd3) state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (lat_cnt == LAT_LAST) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && out_idx == 2'd3) state_next = S_FILL;
      end
      default: state_next = S_FILL;
    endcase
  end

  // {~idx, 5'd0} is the LSB of word idx in big-endian order (idx 0 -> 96).
  always_ff @(posedge clk) begin
    if (rst) begin
      plain_text <= '0;
      word_cnt   <= 2'd0;
      lat_cnt    <= 8'd0;
      out_buf    <= '0;
      out_idx    <= 2'd0;
    end else begin
      if (accept && !is_key) begin
        plain_text[{~word_cnt, 5'd0} +: 32] <= in_data;
        word_cnt <= word_cnt + 2'd1;
        if (word_cnt == 2'd3) lat_cnt <= 8'd0;
      end
      if (state == S_WAIT) begin
        lat_cnt <= lat_cnt + 8'd1;
        if (lat_cnt == LAT_LAST) begin
          out_buf <= cypher_text;
          out_idx <= 2'd0;
        end
      end
      if (out_valid && out_ready) out_idx <= out_idx + 2'd1;
    end
  end

  always_comb begin
    out_data = out_buf[127:96];
    case (out_idx)
      2'd0: out_data = out_buf[127:96];
      2'd1: out_data = out_buf[95:64];
      2'd2: out_data = out_buf[63:32];
      2'd3: out_data = out_buf[31:0];
      default: out_data = out_buf[127:96];
    endcase
  end

endmodule

// File: tb/tb_aes_stream_if.sv
// Testbench for aes_stream_if. A behavioural stand-in for the encrypt path
// returns a known result only in the single cycle that precedes the capture
// edge, so an early or late capture shows up as a wrong output word.
module tb_aes_stream_if;

  localparam int L = 11;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK     = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_key;
  logic [127:0] plain_text;
  logic [127:0] key_in;
  logic [127:0] key_out;
  logic [127:0] cypher_text;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  aes_stream_if #(.CORE_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .plain_text(plain_text), .key_in(key_in), .key_out(key_out),
    .cypher_text(cypher_text),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] k);
    if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return pt ^ {k[63:0], k[127:64]} ^ 128'h5a5aa5a5_3c3cc3c3_0ff0f00f_96696996;
  endfunction

  logic key_word;
`ifdef AES_KEY_LOAD_EN
  assign key_word = in_key;
`else
  assign key_word = 1'b0;
`endif

  // Encrypt-path stand-in: 'since' counts edges after the 4th plaintext accept.
  bit acc_pending = 0;
  int since = 1000;
  int pcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      acc_pending = 0;
      since = 1000;
      pcnt = 0;
    end else begin
      if (acc_pending) since = 0;
      else if (since < 1000) since++;
      acc_pending = 0;
      if (in_valid && in_ready && !key_word) begin
        if (pcnt == 3) acc_pending = 1;
        pcnt = (pcnt + 1) % 4;
      end
    end
    cypher_text = (since == L - 1) ? core_fn(plain_text, key_out) : JUNK;
  end

  // Scoreboard: every output handshake pops and compares one expected word.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word unexpected: got %h, none expected", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL out_word: got %h exp %h", out_data, e);
        end
      end
      hs_count++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1.
  task automatic send_word(input logic [31:0] d, input logic k);
    int t = 0;
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        checks++; errors++;
        $display("FAIL send_word timeout: in_ready got %b exp 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_key   = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] key,
                            input int gap, input bit push);
    logic [127:0] ct;
    if (push) begin
      ct = core_fn(pt, key);
      for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
    end
`ifdef AES_KEY_LOAD_EN
    for (int i = 0; i < 4; i++) begin
      send_word(key[127-32*i -: 32], 1'b1);
      idle(gap);
      send_word(pt[127-32*i -: 32], 1'b0);
      if (i < 3) idle(gap);
    end
`else
    key_in = key;
    for (int i = 0; i < 4; i++) begin
      send_word(pt[127-32*i -: 32], 1'b0);
      if (i < 3) idle(gap);
    end
`endif
  endtask

  task automatic wait_drain();
    int t = 0;
    forever begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy) break;
      t++;
      if (t > 400) break;
    end
    checks++;
    if (t > 400) begin
      errors++;
      $display("FAIL drain timeout: queued %0d busy %b exp 0 0", exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_key = 1'b0; in_data = '0;
    out_ready = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if (plain_text !== 128'h0) begin errors++; $display("FAIL rst_plain_text got %h exp 0", plain_text); end
`ifdef AES_KEY_LOAD_EN
    checks++; if (key_out !== 128'h0) begin errors++; $display("FAIL rst_key_out got %h exp 0", key_out); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fips();
    out_ready = 1'b1;
    send_block(FIPS_PT, FIPS_KEY, 0, 1);
    @(negedge clk);
    checks++; if (plain_text !== FIPS_PT) begin errors++; $display("FAIL fips_plain_text got %h exp %h", plain_text, FIPS_PT); end
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fips_wait busy/in_ready got %b%b exp 10", busy, in_ready); end
    wait_drain();
  endtask

  task automatic test_gaps();
    int k = 0;
    out_ready = 1'b1;
    send_block(FIPS_PT, FIPS_KEY, 3, 1);
    forever begin
      @(negedge clk);
      if (out_valid || k > 300) break;
      k++;
    end
    checks++; if (k != L) begin errors++; $display("FAIL gaps_latency got %0d exp %0d", k, L); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [127:0] pt = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    logic [31:0] w0;
    int t = 0;
    out_ready = 1'b0;
    send_block(pt, FIPS_KEY, 0, 1);
    w0 = exp_q[0];
    forever begin
      @(negedge clk);
      if (out_valid || t > 300) break;
      t++;
    end
    repeat (5) begin
      @(negedge clk);
      checks++; if (out_data !== w0) begin errors++; $display("FAIL hold_out_data got %h exp %h", out_data, w0); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_flags in_ready/out_valid got %b%b exp 01", in_ready, out_valid); end
      checks++; if (plain_text !== pt) begin errors++; $display("FAIL hold_plain_text got %h exp %h", plain_text, pt); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic check_after_reset(input string name);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || plain_text !== 128'h0) begin
      errors++;
      $display("FAIL %s got out_valid %b in_ready %b busy %b plain_text %h exp 0 1 0 0",
               name, out_valid, in_ready, busy, plain_text);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int t = 0;
    logic [127:0] pt = 128'hfedcba9876543210_0123456789abcdef;
    out_ready = 1'b1;
    send_block(FIPS_PT, FIPS_KEY, 0, 0);
    idle(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_after_reset("rst_in_wait");
    @(posedge clk); #1;
    base = hs_count;
    send_block(pt, FIPS_KEY, 0, 1);
    forever begin
      @(negedge clk); #1;
      if (hs_count >= base + 2 || t > 300) break;
      t++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_after_reset("rst_in_drain");
    @(posedge clk); #1;
    send_block(FIPS_PT, FIPS_KEY, 1, 1);
    wait_drain();
  endtask

  task automatic b2b_watch(input int base);
    int t = 0;
    forever begin
      @(negedge clk); #1;
      if (hs_count >= base + 4 || t > 400) break;
      t++;
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_last_drain in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int base;
    out_ready = 1'b1;
    base = hs_count;
    send_block(FIPS_PT, FIPS_KEY, 0, 1);
    fork
      send_block(128'h3243f6a8885a308d313198a2e0370734, FIPS_KEY, 0, 1);
      b2b_watch(base);
    join
    wait_drain();
  endtask

`ifdef AES_KEY_LOAD_EN
  task automatic test_key_load();
    out_ready = 1'b1;
    key_in = {4{32'hffff0000}};
    send_word(FIPS_PT[127:96], 1'b0);
    send_word(FIPS_KEY[127:96], 1'b1);
    send_word(FIPS_PT[95:64], 1'b0);
    send_word(FIPS_KEY[95:64], 1'b1);
    send_word(FIPS_PT[63:32], 1'b0);
    send_word(FIPS_KEY[63:32], 1'b1);
    send_word(FIPS_KEY[31:0], 1'b1);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL key_no_wait busy/in_ready got %b%b exp 01", busy, in_ready); end
    checks++; if (key_out !== FIPS_KEY) begin errors++; $display("FAIL key_out got %h exp %h", key_out, FIPS_KEY); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(FIPS_CT[127-32*i -: 32]);
    send_word(FIPS_PT[31:0], 1'b0);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL key_wait busy/in_ready got %b%b exp 10", busy, in_ready); end
    checks++; if (plain_text !== FIPS_PT) begin errors++; $display("FAIL key_plain_text got %h exp %h", plain_text, FIPS_PT); end
    wait_drain();
  endtask
`else
  task automatic test_key_ignored();
    out_ready = 1'b1;
    key_in = FIPS_KEY;
    for (int i = 0; i < 4; i++) exp_q.push_back(FIPS_CT[127-32*i -: 32]);
    for (int i = 0; i < 4; i++) send_word(FIPS_PT[127-32*i -: 32], 1'b1);
    @(negedge clk);
    checks++; if (plain_text !== FIPS_PT) begin errors++; $display("FAIL keyign_plain_text got %h exp %h", plain_text, FIPS_PT); end
    checks++; if (key_out !== FIPS_KEY) begin errors++; $display("FAIL keyign_key_out got %h exp %h", key_out, FIPS_KEY); end
    wait_drain();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fips();
    test_gaps();
    test_backpressure();
    test_reset_mid();
`ifdef AES_KEY_LOAD_EN
    test_key_load();
`else
    test_key_ignored();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_stream_if.md
# aes_stream_if

Word-stream front end for the AES-128 datapath. It packs four 32-bit input words into the 128-bit `plain_text` block that drives the encrypt path, and holds that block stable for a fixed core latency. It then captures the 128-bit `cypher_text` result and streams it back out as four 32-bit words over a valid/ready handshake. It sits directly upstream of, and wraps around, the key-expansion/encrypt top level.

## Interface

Parameters:
- `CORE_LATENCY`, default 11: clock edges between `plain_text` update and a valid `cypher_text`; legal range 1..255.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 32: input word.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts a word this cycle.
- `in_key` input 1: word is a key word. Used only with `AES_KEY_LOAD_EN`.
- `plain_text` output 128: registered block to the encrypt path.
- `key_in` input 128: external key. Used only without `AES_KEY_LOAD_EN`.
- `key_out` output 128: key to the key-expansion stage.
- `cypher_text` input 128: result from the encrypt path.
- `out_data` output 32: output word.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: the downstream side accepts the word.
- `busy` output 1: high in WAIT or DRAIN.

## Operation

- FSM states: FILL, WAIT, DRAIN. Reset state is FILL.
- Word order is big-endian FIPS-197 order:
  - word 0 maps to bits [127:96], word 3 maps to bits [31:0].
  - This applies both to packing and to unpacking.
- Acceptance: a word is accepted on an edge where `in_valid && in_ready`.
- FILL:
  - `in_ready`=1.
  - Each accepted plaintext word is written into `plain_text[127-32*i -: 32]`, where i is the 2-bit word counter; the counter then increments.
  - On acceptance of word 3: the counter wraps to 0, the state goes to WAIT, and the latency counter is cleared.
  - `plain_text` updates word-by-word. The encrypt path's output is ignored until WAIT completes.
- WAIT:
  - `in_ready`=0.
  - The latency counter increments every edge.
  - On the edge where the counter equals `CORE_LATENCY-1`, `cypher_text` is captured into a 128-bit output buffer. The state goes to DRAIN and the output word index is cleared.
- DRAIN:
  - `out_valid`=1 and `out_data` = buffer word at the current index.
  - An edge with `out_ready`=1 advances the index.
  - On the handshake of word 3, the state returns to FILL.
  - While `out_ready`=0, `out_data` holds stable.
- `in_valid` is ignored outside FILL. No word is ever dropped: the upstream side must hold it.
- `plain_text` is not modified during WAIT or DRAIN.

## Timing

- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `plain_text`=0.
  - All counters and the output buffer are 0.
  - `key_out` is 0 when `AES_KEY_LOAD_EN` is defined.
- Latency: the last input word is accepted at edge E. The capture happens at edge E+`CORE_LATENCY`, and `out_valid` is high in the following cycle.
- Best-case throughput is one block per 4 + `CORE_LATENCY` + 4 cycles. There is no overlap between blocks.
- `in_ready` and `out_valid` are derived from state only, never combinationally from `in_valid` or `out_ready`.
- Reset asserted mid-operation (any state): on the next edge, everything returns to reset values. A partial block or partial drain is discarded.
- Back-to-back: after DRAIN word 3 is handshaken, `in_ready`=1 in the next cycle.

## Configuration

- Macro: `AES_KEY_LOAD_EN`.
- Defined:
  - In FILL, an accepted word with `in_key`=1 goes to a 128-bit key register, using a separate 2-bit key word counter with the same ordering.
  - Key words do not advance the plaintext counter and never trigger WAIT.
  - `key_out` = key register. `key_in` is ignored.
- Undefined:
  - `key_out` = `key_in`, combinationally.
  - `in_key` is ignored, and every accepted word is plaintext.

## Test plan

- Reset, then FIPS-197 C.1 plaintext words 00112233, 44556677, 8899aabb, ccddeeff with key 000102..0f, and `out_ready`=1.
  - Required: `plain_text` = 00112233445566778899aabbccddeeff.
  - Required: `out_data` sequence 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- Same stimulus with `in_valid` gaps between words.
  - Required: identical output.
  - Required: the capture occurs exactly `CORE_LATENCY` edges after the 4th accept.
- During DRAIN, hold `out_ready`=0 for 5 cycles.
  - Required: `out_data` is stable at word 0 and `in_ready`=0.
  - Required: after release, words 1–3 follow.
- Assert `rst` in WAIT, then again in DRAIN after 2 output words.
  - Required: next cycle `out_valid`=0, `in_ready`=1, `plain_text`=0.
  - Required: a fresh block then encrypts correctly.
- With `AES_KEY_LOAD_EN`: send key words 00010203, 04050607, 08090a0b, 0c0d0e0f with `in_key`=1, interleaved with the plaintext words.
  - Required: `key_out` = 000102030405060708090a0b0c0d0e0f.
  - Required: WAIT starts only after the 4th plaintext word.
  - Required: output matches the first scenario.
- Two back-to-back blocks with `out_ready`=1.
  - Required: the second block's `in_ready` goes high the cycle after the first block's final output handshake.
  - Required: both ciphertexts are correct.
